// File: rtl/seg7_scan_capture.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus (segments + anodes).
// Optional SEG7_CAP_STICKY_ERR_EN: err becomes sticky and an err_clr input is added.
module seg7_scan_capture #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    err,
    output logic                    frame_done
`ifdef SEG7_CAP_STICKY_ERR_EN
    ,
    input  logic                    err_clr
`endif
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic {SETTLE, HELD} state_t;

    logic [6:0]            seg_m, seg_s, seg_q;
    logic [NUM_DIGITS-1:0] an_m, an_s, an_q;
    logic [CW-1:0]         cnt;
    state_t                state;
    logic [NUM_DIGITS-1:0] seen_q;

    logic                  s_chg_c;
    logic                  cap_c;
    logic [NUM_DIGITS-1:0] an_lit_c;
    logic                  multi_c;
    logic                  one_cold_c;
    logic [4:0]            dec_c;
    logic                  dark_c;
    logic [NUM_DIGITS-1:0] hit_c;
    logic                  err_evt_c;
    logic [NUM_DIGITS-1:0] seen_set_c;

    // Returns {legal, nibble}; legal=0 for any pattern outside the hex glyph set.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: return {1'b1, 4'h0};
            7'b1001111: return {1'b1, 4'h1};
            7'b0010010: return {1'b1, 4'h2};
            7'b0000110: return {1'b1, 4'h3};
            7'b1001100: return {1'b1, 4'h4};
            7'b0100100: return {1'b1, 4'h5};
            7'b0100000: return {1'b1, 4'h6};
            7'b0001111: return {1'b1, 4'h7};
            7'b0000000: return {1'b1, 4'h8};
            7'b0000100: return {1'b1, 4'h9};
            7'b0001000: return {1'b1, 4'hA};
            7'b1100000: return {1'b1, 4'hB};
            7'b0110001: return {1'b1, 4'hC};
            7'b1000010: return {1'b1, 4'hD};
            7'b0110000: return {1'b1, 4'hE};
            7'b0111000: return {1'b1, 4'hF};
            default:    return 5'b0;
        endcase
    endfunction

    // Capture decodes the previous sample, which has been stable for STABLE_CYCLES samples.
    always_comb begin
        s_chg_c    = {an_s, seg_s} != {an_q, seg_q};
        cap_c      = (state == SETTLE) && (cnt == CW'(STABLE_CYCLES));
        an_lit_c   = ~an_q;
        multi_c    = (an_lit_c & (an_lit_c - NUM_DIGITS'(1))) != '0;
        one_cold_c = (an_lit_c != '0) && !multi_c;
        dec_c      = decode(seg_q);
        dark_c     = (seg_q == 7'h7f);
        hit_c      = (cap_c && one_cold_c && (dec_c[4] || dark_c)) ? an_lit_c : '0;
        err_evt_c  = cap_c && (multi_c || (one_cold_c && !dec_c[4] && !dark_c));
        seen_set_c = seen_q | hit_c;
    end

    // Two-flop synchronisers, preset to the inactive (all-ones) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= '1;
            seg_s <= '1;
            an_m  <= '1;
            an_s  <= '1;
        end else begin
            seg_m <= seg;
            seg_s <= seg_m;
            an_m  <= an;
            an_s  <= an_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q       <= '1;
            an_q        <= '1;
            cnt         <= '0;
            state       <= SETTLE;
            seen_q      <= '0;
            digits      <= '0;
            digit_valid <= '0;
            blank       <= '0;
            err         <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            seg_q <= seg_s;
            an_q  <= an_s;

            if (s_chg_c) begin
                cnt   <= CW'(1);
                state <= SETTLE;
            end else begin
                if (cnt != CW'(STABLE_CYCLES)) cnt <= cnt + CW'(1);
                if (cap_c) state <= HELD;
            end

            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (hit_c[i]) begin
                    if (dec_c[4]) begin
                        digits[4*i +: 4] <= dec_c[3:0];
                        digit_valid[i]   <= 1'b1;
                        blank[i]         <= 1'b0;
                    end else begin
                        blank[i] <= 1'b1;
                    end
                end
            end

            if (&seen_set_c) begin
                frame_done <= 1'b1;
                seen_q     <= '0;
            end else begin
                frame_done <= 1'b0;
                seen_q     <= seen_set_c;
            end

`ifdef SEG7_CAP_STICKY_ERR_EN
            err <= err_evt_c | (err & ~err_clr);
`else
            err <= err_evt_c;
`endif
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture (NUM_DIGITS=4, STABLE_CYCLES=4).
// Define SEG7_CAP_STICKY_ERR_EN to exercise the sticky-error build.
module tb_seg7_scan_capture;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  blank;
    logic        err;
    logic        frame_done;
`ifdef SEG7_CAP_STICKY_ERR_EN
    logic        err_clr;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    seg7_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .digits      (digits),
        .digit_valid (digit_valid),
        .blank       (blank),
        .err         (err),
        .frame_done  (frame_done)
`ifdef SEG7_CAP_STICKY_ERR_EN
        ,
        .err_clr     (err_clr)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic [15:0] digits;
        logic [3:0]  valid;
        logic [3:0]  blank;
        int          errs;
        int          frames;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n cycles, sampling 1ns after each rising edge.
    task automatic run(input int n, output int errs, output int frames);
        errs   = 0;
        frames = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (err) errs++;
            if (frame_done) frames++;
        end
    endtask

    initial begin
        int e, f, e2, f2, hi;

        tbl[0]  = '{4'b1110, 7'b1001111, 16'h0001, 4'b0001, 4'b0000, 0, 0};
        tbl[1]  = '{4'b1101, 7'b0001000, 16'h00A1, 4'b0011, 4'b0000, 0, 0};
        tbl[2]  = '{4'b1011, 7'b0100000, 16'h06A1, 4'b0111, 4'b0000, 0, 0};
        tbl[3]  = '{4'b0111, 7'b0111000, 16'hF6A1, 4'b1111, 4'b0000, 0, 1};
        tbl[4]  = '{4'b1101, 7'b0100100, 16'hF651, 4'b1111, 4'b0000, 0, 0};
        tbl[5]  = '{4'b1101, 7'b1111111, 16'hF651, 4'b1111, 4'b0010, 0, 0};
        tbl[6]  = '{4'b1110, 7'b1111110, 16'hF651, 4'b1111, 4'b0010, 1, 0};
        tbl[7]  = '{4'b1100, 7'b0000001, 16'hF651, 4'b1111, 4'b0010, 1, 0};
        tbl[8]  = '{4'b1111, 7'b0000000, 16'hF651, 4'b1111, 4'b0010, 0, 0};
        tbl[9]  = '{4'b1011, 7'b0000000, 16'hF851, 4'b1111, 4'b0010, 0, 0};
        tbl[10] = '{4'b1110, 7'b0110001, 16'hF85C, 4'b1111, 4'b0010, 0, 0};
        tbl[11] = '{4'b0111, 7'b1000010, 16'hD85C, 4'b1111, 4'b0010, 0, 1};
        tbl[12] = '{4'b1101, 7'b1100000, 16'hD8BC, 4'b1111, 4'b0000, 0, 0};

        rst_n = 1'b0;
        seg   = 7'h7f;
        an    = 4'hf;
`ifdef SEG7_CAP_STICKY_ERR_EN
        err_clr = 1'b0;
`endif
        #1;
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_valid", 32'(digit_valid), 32'h0);
        chk("reset_blank", 32'(blank), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        chk("reset_frame", 32'(frame_done), 32'h0);
        run(3, e, f);
        rst_n = 1'b1;

        // First capture lands on the 7th edge after the pins change.
        an  = 4'b1110;
        seg = 7'b0010010;
        run(6, e, f);
        chk("lat_before_valid", 32'(digit_valid), 32'h0);
        run(1, e2, f2);
        chk("lat_edge7_digits", 32'(digits), 32'h0002);
        chk("lat_edge7_valid", 32'(digit_valid), 32'h1);
        run(3, e2, f2);
        chk("lat_errs", 32'(e + e2), 32'h0);

        for (int v = 0; v < 13; v++) begin
            an  = tbl[v].an;
            seg = tbl[v].seg;
            run(8, e, f);
            chk($sformatf("vec%0d_digits", v), 32'(digits), 32'(tbl[v].digits));
            chk($sformatf("vec%0d_valid", v), 32'(digit_valid), 32'(tbl[v].valid));
            chk($sformatf("vec%0d_blank", v), 32'(blank), 32'(tbl[v].blank));
            chk($sformatf("vec%0d_frames", v), 32'(f), 32'(tbl[v].frames));
`ifdef SEG7_CAP_STICKY_ERR_EN
            chk($sformatf("vec%0d_err", v), 32'(e > 0), 32'(tbl[v].errs > 0));
            if (e > 0) begin
                err_clr = 1'b1;
                run(1, e2, f2);
                err_clr = 1'b0;
            end
`else
            chk($sformatf("vec%0d_errs", v), 32'(e), 32'(tbl[v].errs));
`endif
        end

        // Glitch rejection: 3-cycle toggles never reach the stability threshold.
        an = 4'b1110;
        e2 = 0;
        f2 = 0;
        for (int p = 0; p < 10; p++) begin
            seg = (p % 2 == 0) ? 7'b0000001 : 7'b1001111;
            run(3, e, f);
            e2 += e;
            f2 += f;
        end
        an  = 4'hf;
        seg = 7'h7f;
        run(10, e, f);
        chk("glitch_digits", 32'(digits), 32'hD8BC);
        chk("glitch_valid", 32'(digit_valid), 32'hF);
        chk("glitch_errs", 32'(e + e2), 32'h0);
        chk("glitch_frames", 32'(f + f2), 32'h0);

        // Mid-operation reset with a glyph already at the pins.
        an    = 4'b0111;
        seg   = 7'b0110000;
        rst_n = 1'b0;
        #1;
        chk("midrst_digits", 32'(digits), 32'h0);
        chk("midrst_valid", 32'(digit_valid), 32'h0);
        chk("midrst_blank", 32'(blank), 32'h0);
        #2;
        rst_n = 1'b1;
        run(6, e, f);
        chk("midrst_before_valid", 32'(digit_valid), 32'h0);
        run(1, e, f);
        chk("midrst_edge7_digits", 32'(digits), 32'hE000);
        chk("midrst_edge7_valid", 32'(digit_valid), 32'h8);

`ifdef SEG7_CAP_STICKY_ERR_EN
        an  = 4'b1110;
        seg = 7'b1111110;
        run(7, e, f);
        chk("sticky_set", 32'(err), 32'h1);
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            run(1, e, f);
            if (err) hi++;
        end
        chk("sticky_hold20", 32'(hi), 32'd20);
        err_clr = 1'b1;
        run(1, e, f);
        err_clr = 1'b0;
        chk("sticky_clear", 32'(err), 32'h0);
        seg = 7'b1111100;
        run(6, e, f);
        chk("sticky_pre_event", 32'(err), 32'h0);
        err_clr = 1'b1;
        run(1, e, f);
        err_clr = 1'b0;
        chk("sticky_set_wins", 32'(err), 32'h1);
        run(1, e, f);
        chk("sticky_after_tie", 32'(err), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Reads back a multiplexed, active-low 7-segment display bus (segments plus digit anodes) and recovers the hex digit each position is showing. It is the inverse of the team's BCD-to-7-segment decoder.
- Used for display loopback self-test and for scraping digit values from external 7-seg-driven modules.
- Synchronises the pins, waits for a stable scan slot, decodes the pattern, and stores it per digit.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before capture (2..255).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- seg  input  7  segment lines {a,b,c,d,e,f,g} = seg[6:0]; active-low (0 = lit).
- an  input  NUM_DIGITS  digit enables; active-low, one-cold when a digit is driven.
- digits  output  4*NUM_DIGITS  recovered nibble per digit; digit i occupies [4i+3:4i].
- digit_valid  output  NUM_DIGITS  bit i set once digit i has captured a legal glyph.
- blank  output  NUM_DIGITS  bit i set when digit i was last seen all-dark (7'b1111111).
- err  output  1  one-cycle pulse on an illegal glyph or illegal anode pattern.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the previous pulse.
- err_clr  input  1  present only when SEG7_CAP_STICKY_ERR_EN is defined.

Behaviour:
- Reset (asynchronous, rst_n low):
  - digits = 0, digit_valid = 0, blank = 0, err = 0, frame_done = 0.
  - Synchroniser flops preset to all-ones (inactive). Stability counter = 0. FSM in SETTLE.
- Input path: seg and an each pass through a 2-flop synchroniser; sampled pair S = {an_s, seg_s}.
- Stability counter:
  - If S differs from the previous sample, cnt loads 1 and the FSM goes to SETTLE.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
- SETTLE -> HELD on the cycle cnt reaches STABLE_CYCLES. The capture action fires once, on that transition only.
- HELD: no further captures. Return to SETTLE on any change of S.
- Capture action, by an_s class:
  - Exactly one zero at bit i: decode seg_s.
  - All ones: nothing captured, no error. Treated as inter-digit blanking.
  - Two or more zeros: err pulse; no digit updated.
- Decode table (seg_s -> nibble):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3.
  - 1001100->4, 0100100->5, 0100000->6, 0001111->7.
  - 0000000->8, 0000100->9, 0001000->A, 1100000->B.
  - 0110001->C, 1000010->D, 0110000->E, 0111000->F.
- Legal glyph: digits[i] = nibble, digit_valid[i] = 1, blank[i] = 0.
- 1111111: blank[i] = 1; digits[i] and digit_valid[i] unchanged.
- Any other pattern: err pulse; digit i registers unchanged.
- Latency: outputs update on the (STABLE_CYCLES+3)th rising edge after the new value first sits at the pins (2 sync + STABLE_CYCLES compare + 1 output register).
- Frame tracking:
  - A seen mask sets bit i on any capture of digit i (legal or blank).
  - When the mask becomes all-ones, frame_done pulses for one cycle and the mask clears in the same cycle.
  - A capture in that same cycle sets its bit in the fresh mask.
- Glitch rejection: a pattern held fewer than STABLE_CYCLES samples is never captured and raises no error.
- Reset mid-operation: all state returns immediately to reset values. The first capture after rst_n deasserts needs a full synchroniser fill plus STABLE_CYCLES.

Optional Feature:
- Macro SEG7_CAP_STICKY_ERR_EN.
- Defined:
  - err is sticky: set by any error event, cleared only by err_clr high for one cycle or by reset.
  - If an error event and err_clr occur in the same cycle, the set wins.
  - err_clr port exists.
- Undefined:
  - err is a one-cycle pulse per error event.
  - err_clr port is absent.

Test Plan:
- Reset, then hold an=4'b1110, seg=7'b0010010 for 10 cycles -> digits[3:0]=2, digit_valid=4'b0001, err=0. Update lands on edge 7 (STABLE_CYCLES=4).
- Scan an=1110/1101/1011/0111 with glyphs 1, A, 6, F, 8 cycles per slot -> digits=16'hF6A1, digit_valid=4'b1111, frame_done single pulse after the 4th capture.
- an=1101, seg=1111111 held 8 cycles after digit 1 holds 5 -> blank[1]=1, digits[7:4]=5 still, digit_valid[1]=1.
- an=1110 with seg=1111110 held 6 cycles -> one err pulse, digits unchanged. an=1100 with a legal glyph -> one err pulse.
- an=1110, seg toggles between 0000001 and 1001111 every 3 cycles for 30 cycles -> no capture, no err, digit_valid unchanged.
- Sticky-error build: force an illegal glyph -> err stays 1 for 20 cycles; pulse err_clr -> err=0 next edge; error and err_clr in the same cycle -> err=1.
